// File: rtl/bist_pkg.sv
// Shared state codes, element index type and the March C- element table
// used by the BIST march controller and its element ROM.
package bist_pkg;

  // FSM state codes
  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_SETUP = 3'd1;
  localparam state_t S_RD    = 3'd2;
  localparam state_t S_CMP   = 3'd3;
  localparam state_t S_WR    = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  // March element index
  typedef logic [2:0] elem_t;

  localparam int    NUM_ELEMENTS = 6;
  localparam elem_t LAST_ELEMENT = elem_t'(NUM_ELEMENTS - 1);

  // Element table, bit i describes element Mi:
  //   M0 up w0, M1 up (r0,w1), M2 up (r1,w0),
  //   M3 down (r0,w1), M4 down (r1,w0), M5 up r0
  localparam logic [NUM_ELEMENTS-1:0] ELEM_UP     = 6'b100111;
  localparam logic [NUM_ELEMENTS-1:0] ELEM_HAS_RD = 6'b111110;
  localparam logic [NUM_ELEMENTS-1:0] ELEM_RD_VAL = 6'b010100;
  localparam logic [NUM_ELEMENTS-1:0] ELEM_HAS_WR = 6'b011111;
  localparam logic [NUM_ELEMENTS-1:0] ELEM_WR_VAL = 6'b001010;

  // Decoded per-element control bundle
  typedef struct packed {
    logic up;
    logic rd_en;
    logic rd_val;
    logic wr_en;
    logic wr_val;
  } elem_cfg_t;

endpackage

// File: rtl/bist_march_rom.sv
// Combinational element ROM: element index to direction, read and write
// controls with their background values. Unused indices decode to all-0.
module bist_march_rom
  import bist_pkg::*;
(
  input  elem_t element,
  output logic  up,
  output logic  rd_en,
  output logic  rd_val,
  output logic  wr_en,
  output logic  wr_val
);

  elem_cfg_t cfg;

  // Table lookup, guarded against the two unused index codes
  always_comb begin
    cfg = '0;
    if (int'(element) < NUM_ELEMENTS) begin
      cfg.up     = ELEM_UP[element];
      cfg.rd_en  = ELEM_HAS_RD[element];
      cfg.rd_val = ELEM_RD_VAL[element];
      cfg.wr_en  = ELEM_HAS_WR[element];
      cfg.wr_val = ELEM_WR_VAL[element];
    end
  end

  assign up     = cfg.up;
  assign rd_en  = cfg.rd_en;
  assign rd_val = cfg.rd_val;
  assign wr_en  = cfg.wr_en;
  assign wr_val = cfg.wr_val;

endmodule

// File: rtl/bist_march_controller.sv
// March C- BIST sequencer: drives the address generator and RAM strobes.
// Optional macro STOP_ON_FAIL_EN ends the test at the first mismatch.
module bist_march_controller
  import bist_pkg::*;
#(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               ag_en,
  output logic               ag_up_down,
  output logic               ag_preset,
  output logic               ag_clear,
  input  logic               ag_carry,
  input  logic [A_WIDTH-1:0] ag_address,
  output logic               mem_re,
  output logic               mem_we,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [A_WIDTH-1:0] fail_addr,
  output logic [2:0]         fail_element
);

`ifdef STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t state;
  state_t state_n;
  elem_t  element;
  elem_t  element_n;

  logic el_up;
  logic el_rd_en;
  logic el_rd_val;
  logic el_wr_en;
  logic el_wr_val;

  logic               in_test;
  logic               take_start;
  logic               mismatch;
  logic               flag;
  logic               stop_now;
  logic [D_WIDTH-1:0] exp_data;

  bist_march_rom u_rom (
    .element (element),
    .up      (el_up),
    .rd_en   (el_rd_en),
    .rd_val  (el_rd_val),
    .wr_en   (el_wr_en),
    .wr_val  (el_wr_val)
  );

  assign in_test = (state == S_SETUP) || (state == S_RD) ||
                   (state == S_CMP)   || (state == S_WR);

  assign take_start = start &&
                      ((state == S_IDLE) || (state == S_DONE));

  assign exp_data = {D_WIDTH{el_rd_val}};

  // X on read data counts as a mismatch in simulation only
`ifdef SYNTHESIS
  assign mismatch = (mem_rdata != exp_data);
`else
  assign mismatch = (mem_rdata !== exp_data);
`endif

  assign flag = (state == S_CMP) && el_rd_en && mismatch && !fail;

  assign stop_now = STOP_ON_FAIL && flag;

  // Direction is held for the whole element, including SETUP
  assign ag_up_down = in_test && el_up;

  // Next-state, strobes and generator controls, all table-driven
  always_comb begin
    state_n   = state;
    element_n = element;
    ag_en     = 1'b0;
    ag_preset = 1'b0;
    ag_clear  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n   = S_SETUP;
          element_n = '0;
        end
      end
      S_SETUP: begin
        ag_clear  = el_up;
        ag_preset = !el_up;
        state_n   = el_rd_en ? S_RD : S_WR;
      end
      S_RD: begin
        mem_re  = 1'b1;
        state_n = S_CMP;
      end
      S_CMP, S_WR: begin
        if (state == S_WR || el_wr_en) begin
          mem_we    = 1'b1;
          mem_wdata = {D_WIDTH{el_wr_val}};
        end
        if (stop_now) begin
          state_n = S_DONE;
        end else if (!ag_carry) begin
          ag_en   = 1'b1;
          state_n = el_rd_en ? S_RD : S_WR;
        end else if (element == LAST_ELEMENT) begin
          state_n = S_DONE;
        end else begin
          element_n = element + elem_t'(1);
          state_n   = S_SETUP;
        end
      end
      default: begin
        state_n   = S_IDLE;
        element_n = '0;
      end
    endcase
  end

  // State, element index and status registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      element      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      fail_addr    <= '0;
      fail_element <= '0;
    end else begin
      state   <= state_n;
      element <= element_n;
      if (take_start) begin
        busy         <= 1'b1;
        done         <= 1'b0;
        fail         <= 1'b0;
        fail_addr    <= '0;
        fail_element <= '0;
      end
      if (in_test && state_n == S_DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (flag) begin
        fail         <= 1'b1;
        fail_addr    <= ag_address;
        fail_element <= element;
      end
    end
  end

endmodule

// File: tb/tb_bist_march_controller.sv
// Scoreboard bench for bist_march_controller with an address generator
// and RAM model; run summaries are checked when done rises.
module tb_bist_march_controller;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          ag_en, ag_up_down, ag_preset, ag_clear, ag_carry;
  logic [AW-1:0] ag_address;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_element;

  int checks = 0;
  int failures = 0;

  bist_march_controller #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ag_en        (ag_en),
    .ag_up_down   (ag_up_down),
    .ag_preset    (ag_preset),
    .ag_clear     (ag_clear),
    .ag_carry     (ag_carry),
    .ag_address   (ag_address),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_addr    (fail_addr),
    .fail_element (fail_element)
  );

  always #5 clk = ~clk;

  // address generator model
  logic [AW-1:0] addr_q = '0;
  assign ag_address = addr_q;
  assign ag_carry   = ag_up_down ? (addr_q == {AW{1'b1}})
                                 : (addr_q == '0);

  always @(posedge clk) begin
    if (ag_clear)       addr_q <= '0;
    else if (ag_preset) addr_q <= '1;
    else if (ag_en)     addr_q <= ag_up_down ? addr_q + 1'b1
                                             : addr_q - 1'b1;
  end

  // RAM model with optional stuck-at-0 on bit 0 of address 5
  logic [DW-1:0] mem [N];
  logic          fault_en = 1'b0;
  logic [DW-1:0] rd_q = '0;
  assign mem_rdata = rd_q;

  initial for (int i = 0; i < N; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (mem_we) begin
      if (fault_en && ag_address == AW'(5))
        mem[ag_address] <= mem_wdata & ~DW'(1);
      else
        mem[ag_address] <= mem_wdata;
    end
    if (mem_re) rd_q <= mem[ag_address];
  end

  typedef struct {
    int cyc;
    int fl;
    int fa;
    int fe;
    int re;
    int we;
    int pre;
    int clr;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // monitor: per-run counters, direction probe, scoreboard pop
  int   cyc, re_n, we_n, pre_n, clr_n;
  logic busy_q = 1'b0;
  logic done_q = 1'b0;
  bit   pend = 1'b0;
  int   pend_addr;
  exp_t e;

  always @(negedge clk) begin
    if (pend) begin
      chk("first_addr", int'(ag_address), pend_addr);
      pend = 1'b0;
    end
    if (busy && !busy_q) begin
      cyc = 0; re_n = 0; we_n = 0; pre_n = 0; clr_n = 0;
    end
    if (busy) begin
      cyc++;
      re_n  += int'(mem_re);
      we_n  += int'(mem_we);
      pre_n += int'(ag_preset);
      clr_n += int'(ag_clear);
      if (ag_preset || ag_clear) begin
        chk("setup_dir", int'({ag_preset, ag_clear, ag_up_down}),
            ag_clear ? 3'b011 : 3'b100);
        pend = 1'b1;
        pend_addr = ag_clear ? 0 : N - 1;
      end
    end
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        chk("sb_empty_on_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("cycles", cyc, e.cyc);
        chk("fail", int'(fail), e.fl);
        chk("fail_addr", int'(fail_addr), e.fa);
        chk("fail_element", int'(fail_element), e.fe);
        chk("re_count", re_n, e.re);
        chk("we_count", we_n, e.we);
        chk("preset_count", pre_n, e.pre);
        chk("clear_count", clr_n, e.clr);
        chk("busy_at_done", int'(busy), 0);
      end
    end
    busy_q = busy;
    done_q = done;
  end

  task automatic push(input int c, input int f, input int a,
                      input int el, input int r, input int w,
                      input int p, input int cl);
    exp_t x;
    x.cyc = c; x.fl = f; x.fa = a; x.fe = el;
    x.re = r; x.we = w; x.pre = p; x.clr = cl;
    sb.push_back(x);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 400) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, int'({ag_en, ag_up_down, ag_preset, ag_clear, mem_re, mem_we,
                  mem_wdata, busy, done, fail, fail_addr, fail_element}), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    reset = 1'b1;

    // good RAM, with an ignored start pulse mid-run
    push(11 * N + 6, 0, 0, 0, 5 * N, 5 * N, 2, 4);
    pulse_start();
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mid", int'(busy), 1);
    wait_done();

    // stuck-at-0 bit 0 at address 5
    fault_en = 1'b1;
`ifdef STOP_ON_FAIL_EN
    push(63, 1, 5, 2, 22, 38, 0, 3);
`else
    push(11 * N + 6, 1, 5, 2, 5 * N, 5 * N, 2, 4);
`endif
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
    chk("done_held", int'({done, fail}), 2'b11);

    // restart from DONE on a good RAM clears status next edge
    fault_en = 1'b0;
    push(11 * N + 6, 0, 0, 0, 5 * N, 5 * N, 2, 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_status", int'({busy, done, fail}), 3'b100);
    wait_done();

    // reset in the middle of a run
    pulse_start();
    repeat (48) @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_zero("reset_mid_run");
    reset = 1'b1;
    push(11 * N + 6, 0, 0, 0, 5 * N, 5 * N, 2, 4);
    pulse_start();
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
